// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Define CLA_PIPE_FLAGS_EN to add the registered ovf/zero flag outputs.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int unsigned NG = WIDTH / 4;

    logic             en1, en2;
    logic             v1_q, v1_d, v2_q, v2_d;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] p_q, p_d, g_q, g_d;
    logic [NG-1:0]    gp_q, gp_d, gg_q, gg_d;
    logic             c0_q, c0_d;
    logic [NG:0]      gc;
    logic [WIDTH:0]   bc;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef CLA_PIPE_FLAGS_EN
    logic             ovf_q, ovf_d, zero_q, zero_d;
`endif

    // Carry into position n of a lookahead chain, as a flat sum of products.
    function automatic logic la_carry(input logic [WIDTH-1:0] pp,
                                      input logic [WIDTH-1:0] gg,
                                      input logic             ci,
                                      input int unsigned      n);
        logic c;
        logic t;
        c = ci;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            if (j < n) c = c & pp[j];
        end
        for (int unsigned j = 0; j < WIDTH; j++) begin
            if (j < n) begin
                t = gg[j];
                for (int unsigned m = 0; m < WIDTH; m++) begin
                    if (m > j && m < n) t = t & pp[m];
                end
                c = c | t;
            end
        end
        return c;
    endfunction

    always_comb begin : handshake
        en2 = ~v2_q | out_ready;
        en1 = ~v1_q | en2;
    end

    assign in_ready = en1;

    // Stage 1: per-bit propagate/generate and per-group P/G.
    always_comb begin : stage1
        bx   = sub ? ~b : b;
        v1_d = en1 ? in_valid : v1_q;
        p_d  = p_q;
        g_d  = g_q;
        gp_d = gp_q;
        gg_d = gg_q;
        c0_d = c0_q;
        if (en1 && in_valid) begin
            p_d  = a ^ bx;
            g_d  = a & bx;
            c0_d = sub | cin;
            for (int unsigned k = 0; k < NG; k++) begin
                gp_d[k] = &p_d[4*k +: 4];
                gg_d[k] = g_d[4*k+3]
                        | (p_d[4*k+3] & g_d[4*k+2])
                        | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
                        | (&p_d[4*k+1 +: 3] & g_d[4*k]);
            end
        end
    end

    // Stage 2: group carries, in-group carries, then sum.
    always_comb begin : stage2
        gc = '0;
        bc = '0;
        for (int unsigned k = 0; k <= NG; k++) begin
            gc[k] = la_carry(WIDTH'(gp_q), WIDTH'(gg_q), c0_q, k);
        end
        for (int unsigned k = 0; k < NG; k++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                bc[4*k+i] = la_carry(WIDTH'(p_q[4*k +: 4]), WIDTH'(g_q[4*k +: 4]), gc[k], i);
            end
        end
        bc[WIDTH] = gc[NG];

        v2_d   = en2 ? v1_q : v2_q;
        sum_d  = sum_q;
        cout_d = cout_q;
`ifdef CLA_PIPE_FLAGS_EN
        ovf_d  = ovf_q;
        zero_d = zero_q;
`endif
        if (en2 && v1_q) begin
            sum_d  = p_q ^ bc[WIDTH-1:0];
            cout_d = gc[NG];
`ifdef CLA_PIPE_FLAGS_EN
            ovf_d  = bc[WIDTH-1] ^ gc[NG];
            zero_d = ~|(p_q ^ bc[WIDTH-1:0]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            p_q    <= '0;
            g_q    <= '0;
            gp_q   <= '0;
            gg_q   <= '0;
            c0_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
`endif
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            p_q    <= p_d;
            g_q    <= g_d;
            gp_q   <= gp_d;
            gg_q   <= gg_d;
            c0_q   <= c0_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
`ifdef CLA_PIPE_FLAGS_EN
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
`endif
        end
    end

    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_PIPE_FLAGS_EN
    assign ovf       = ovf_q;
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed vectors, back-pressure,
// reset flush and random traffic against an arithmetic reference model.
module tb_cla_pipe_adder;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
`ifdef CLA_PIPE_FLAGS_EN
    logic         ovf, zero;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    int   nchk = 0;
    int   nfail = 0;
    int   emit_cnt = 0;
    res_t exp_q[$];
    res_t mon_e;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef CLA_PIPE_FLAGS_EN
        , .ovf(ovf), .zero(zero)
`endif
    );

    // Reference: plain modular arithmetic plus sign-rule overflow.
    function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic ci, input logic sb);
        res_t         r;
        logic [W-1:0] bv;
        logic [W:0]   full;
        bv     = sb ? ~bb : bb;
        full   = {1'b0, aa} + {1'b0, bv} + (W+1)'(sb ? 1'b1 : ci);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (aa[W-1] == bv[W-1]) && (r.sum[W-1] != aa[W-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_res(input string nm, input res_t e);
        chk({nm, " sum"}, 32'(sum), 32'(e.sum));
        chk({nm, " cout"}, 32'(cout), 32'(e.cout));
`ifdef CLA_PIPE_FLAGS_EN
        chk({nm, " ovf"}, 32'(ovf), 32'(e.ovf));
        chk({nm, " zero"}, 32'(zero), 32'(e.zero));
`endif
    endtask

    // Scoreboard: capture accepted beats, compare emitted results in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                emit_cnt++;
                chk("scoreboard beat expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_res("scoreboard", mon_e);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        end
    end

    // One beat with out_ready high: checks two-cycle latency and the result.
    task automatic run_vec(input string nm, input vec_t v);
        res_t e;
        @(posedge clk); #1;
        in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; sub = v.sub; out_ready = 1'b1;
        #1 chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~v.a; b = ~v.b;
        #1 chk({nm, " valid early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #2;
        chk({nm, " valid at latency"}, 32'(out_valid), 32'd1);
        e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf; e.zero = v.zero;
        check_res(nm, e);
    endtask

    vec_t         vt[7];
    logic [W-1:0] ba[5], bb[5];
    logic         bc[5], bs[5];
    res_t         exp0;
    int           idx, ocnt, first, last, snap;

    initial begin
        vt[0] = '{16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vt[3] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vt[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vt[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vt[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
`ifdef CLA_PIPE_FLAGS_EN
        chk("reset ovf", 32'(ovf), 32'd0);
        chk("reset zero", 32'(zero), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vt[i]);

        // Back-pressure: five beats, output stalled for the first four cycles.
        for (int i = 0; i < 5; i++) begin
            ba[i] = W'($urandom); bb[i] = W'($urandom);
            bc[i] = 1'($urandom); bs[i] = 1'($urandom);
        end
        exp0 = model(ba[0], bb[0], bc[0], bs[0]);
        idx = 0; ocnt = 0; first = -1; last = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 4);
            if (idx < 5) begin
                in_valid = 1'b1; a = ba[idx]; b = bb[idx]; cin = bc[idx]; sub = bs[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 2) chk("bp in_ready open", 32'(in_ready), 32'd1);
            if (c == 2 || c == 3) begin
                chk("bp in_ready full", 32'(in_ready), 32'd0);
                chk("bp out_valid held", 32'(out_valid), 32'd1);
                check_res("bp held", exp0);
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                if (first < 0) first = c;
                last = c;
                ocnt++;
            end
        end
        chk("bp accepted", 32'(idx), 32'd5);
        chk("bp emitted", 32'(ocnt), 32'd5);
        chk("bp first emit cycle", 32'(first), 32'd4);
        chk("bp last emit cycle", 32'(last), 32'd8);

        // Reset with two beats in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 16'h3333; b = 16'h4444;
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1; a = 16'h5555;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst flush out_valid", 32'(out_valid), 32'd0);
        chk("rst flush sum", 32'(sum), 32'd0);
        chk("rst flush in_ready", 32'(in_ready), 32'd1);
        snap = emit_cnt;
        repeat (4) @(posedge clk);
        #2 chk("rst no ghost beats", 32'(emit_cnt), 32'(snap));
        run_vec("post rst", vt[5]);

        // Random traffic with random back-pressure.
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge clk);
        #2 chk("drain queue empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
